// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Initiator for the data-memory stage. Takes one load/store
//               request at a time from the pipeline, performs word, halfword
//               and byte accesses against a word-only synchronous memory, and
//               returns a one-cycle response with extended load data or an
//               error flag. Sub-word stores use read-modify-write.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   req_valid  : request present
//   req_ready  : high in IDLE only; accept = req_valid & req_ready at an edge
//   req_op     : 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
//   req_addr   : byte address
//   req_wdata  : store data (SB uses [7:0], SH uses [15:0])
//   rsp_valid  : one-cycle completion pulse
//   rsp_err    : misaligned / out-of-range flag, held until next response
//   rsp_rdata  : load result (0 for stores and errors), held until next response
//   mem_we     : memory write enable (one cycle, WRITE state only)
//   mem_addr   : byte address to the memory stage
//   mem_wdata  : word to write
//   mem_rdata  : synchronous read data, valid the cycle after mem_addr
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // ------------------------------------------------------------------
    // Operation encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and buffers
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [2:0]  op_q,        op_d;
    logic [31:0] addr_q,      addr_d;
    // Only the low halfword of store data is ever merged; SW data goes
    // straight to mem_wdata on accept.
    logic [15:0] wdata_q,     wdata_d;
    logic [31:0] word_q,      word_d;
    logic        err_q,       err_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    logic w_misaligned;
    logic w_out_of_range;
    logic w_req_bad;

    always_comb begin
        w_misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          w_misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  w_misaligned = req_addr[0];
            default:               w_misaligned = 1'b0;
        endcase
    end

    // Any bit above the memory's byte-address range makes the access invalid.
    assign w_out_of_range = ((req_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0);
    assign w_req_bad      = w_misaligned | w_out_of_range;

    // ------------------------------------------------------------------
    // Little-endian extraction with sign/zero extension
    // ------------------------------------------------------------------
    function automatic logic [31:0] load_extend(
        input logic [2:0]  op,
        input logic [31:0] word,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LW:   r = word;
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Store merge: replace only the addressed byte/halfword
    // ------------------------------------------------------------------
    function automatic logic [31:0] store_merge(
        input logic [2:0]  op,
        input logic [31:0] word,
        input logic [15:0] wd,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = word;
        if (op == OP_SB) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (off[1]) begin
                r[31:16] = wd;
            end else begin
                r[15:0]  = wd;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        err_d       = err_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata[15:0];
                    mem_addr_d = req_addr;
                    err_d      = w_req_bad;
                    if (w_req_bad) begin
                        state_d = ST_RESP;
                    end else if (req_op == OP_SW) begin
                        mem_wdata_d = req_wdata;
                        state_d     = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_addr_d = addr_q;
                state_d    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                word_d = mem_rdata;
                if ((op_q == OP_SB) || (op_q == OP_SH)) begin
                    // Merge from the live read data so the write can issue
                    // on the very next cycle.
                    mem_wdata_d = store_merge(op_q, mem_rdata, wdata_q, addr_q[1:0]);
                    state_d     = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_err_d = err_q;
                if (err_q || (op_q >= OP_SW)) begin
                    rsp_rdata_d = 32'd0;
                end else begin
                    rsp_rdata_d = load_extend(op_q, word_q, addr_q[1:0]);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered handshake/strobe outputs are decoded from the state so
        // they line up with the state they describe; mem_we never depends on
        // an input, so it can only be high for the single WRITE cycle.
        req_ready_d = (state_d == ST_IDLE);
        mem_we_d    = (state_d == ST_WRITE);
        rsp_valid_d = (state_q == ST_RESP);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 16'd0;
            word_q      <= 32'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Scoreboard bench for mem_access_ctrl. A byte-array reference
//               memory predicts every response; a monitor pops and compares
//               on each rsp_valid pulse. A word memory model backs the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_ctrl #(.MEM_WORDS_LOG2(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory (bytes) and DUT-side word memory
    logic [7:0]  ref_bytes [0:4095];
    logic [31:0] dmem      [0:1023];
    logic        load_mem = 1'b0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int w = 0; w < 1024; w++)
                dmem[w] <= {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
        end else begin
            if (mem_we) dmem[mem_addr[11:2]] <= mem_wdata;
            mem_rdata <= dmem[mem_addr[11:2]];
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          nwr;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    // Behavioural model: access size, alignment and range from the op,
    // data assembled byte by byte from the reference memory.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] wd, output exp_t e);
        int          size;
        bit          store;
        bit          sgn;
        logic [31:0] v;
        size  = (op == OP_LW || op == OP_SW) ? 4 :
                (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        store = (op == OP_SW || op == OP_SB || op == OP_SH);
        sgn   = (op == OP_LB || op == OP_LH);
        e.err = (a >= 32'd4096) || ((a % size) != 0);
        e.rd  = 32'd0;
        e.nwr = 0;
        e.acc = 0;
        if (e.err) begin
            e.lat = 1;
        end else if (store) begin
            for (int i = 0; i < size; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
            e.nwr = 1;
            e.lat = (size == 4) ? 2 : 4;
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8*i));
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            e.rd  = v;
            e.lat = 3;
        end
    endfunction

    // Drive a request; returns after the accept edge with req_valid still high.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input bit use_model, output int acc);
        int   guard;
        exp_t e;
        guard     = 0;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready stuck at 0, required 1");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (use_model) begin
            model(op, a, wd, e);
            e.acc = acc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            we_cnt = 0;
        end else begin
            if (mem_we) we_cnt++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_rsp: got rsp_valid=1 expected no response");
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_err",   {31'd0, rsp_err}, {31'd0, mon_e.err});
                    chk("rsp_rdata", rsp_rdata, mon_e.rd);
                    chk("latency",   32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    chk("write_cnt", 32'(we_cnt), 32'(mon_e.nwr));
                    we_cnt = 0;
                end
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
    } dreq_t;

    initial begin
        int    a1, a2, acc;
        dreq_t dir [$];
        logic [2:0]  op;
        logic [31:0] addr;
        int    r;

        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'($urandom);
        ref_bytes[16] = 8'hBB;
        ref_bytes[17] = 8'hAA;
        ref_bytes[18] = 8'h99;
        ref_bytes[19] = 8'h88;

        load_mem = 1'b1;
        repeat (3) @(posedge clk);
        load_mem = 1'b0;
        @(negedge clk);

        // Reset values while reset is held low
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases around the preset word at 0x10
        dir.push_back('{OP_LB,  32'h13,   32'h0});
        dir.push_back('{OP_LBU, 32'h11,   32'h0});
        dir.push_back('{OP_LH,  32'h12,   32'h0});
        dir.push_back('{OP_LHU, 32'h10,   32'h0});
        dir.push_back('{OP_LW,  32'h10,   32'h0});
        dir.push_back('{OP_SB,  32'h12,   32'h1234565C});
        dir.push_back('{OP_LW,  32'h10,   32'h0});
        dir.push_back('{OP_SH,  32'h13,   32'hFFFF});
        dir.push_back('{OP_LW,  32'h16,   32'h0});
        dir.push_back('{OP_LW,  32'h1000, 32'h0});
        dir.push_back('{OP_LB,  32'hFFF,  32'h0});
        foreach (dir[i]) begin
            issue(dir[i].op, dir[i].a, dir[i].wd, 1'b1, acc);
            req_valid = 1'b0;
        end
        drain();
        chk("sb_merged_word", dmem[4], 32'h885CAABB);

        // Reset during CAPTURE of an SB: abort with no response
        issue(OP_SB, 32'h10, 32'h000000EE, 1'b0, acc);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_mem_we",    {31'd0, mem_we},    32'd0);
        chk("abort_mem_addr",  mem_addr,  32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_word_0x10", dmem[4], ref_word(4));
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back with req_valid held high throughout
        issue(OP_SW, 32'h20, 32'hDEADBEEF, 1'b1, a1);
        issue(OP_LW, 32'h20, 32'h0, 1'b1, a2);
        req_valid = 1'b0;
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
        drain();

        // Randomized traffic, sometimes holding req_valid through busy cycles
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 15));
            else if (r == 1) addr = $urandom;
            else             addr = 32'($urandom_range(0, 255));
            issue(op, addr, $urandom, 1'b1, acc);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        drain();

        for (int w = 0; w < 64; w++) chk("final_mem", dmem[w], ref_word(w));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory stage port; it is the block that drives the stage's write enable, byte address, write data and read data.
- Accepts one load/store request at a time from the pipeline and performs word, halfword and byte accesses.
- Sub-word stores are done as read-modify-write, because the memory is word-only.
- Returns a single-cycle response that carries the extended load data or an error flag.

Parameters:
- MEM_WORDS_LOG2, 10, log2 of memory depth in 32-bit words. The valid byte range is 0 to 4*2^MEM_WORDS_LOG2-1.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high in IDLE only; a request is accepted when req_valid&req_ready at a rising edge
- req_op  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
- req_addr  input  32  byte address
- req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0]
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  misaligned or out-of-range access; valid with rsp_valid
- rsp_rdata  output  32  load result; 0 for stores and errors
- mem_we  output  1  memory write enable
- mem_addr  output  32  byte address to the memory stage; the memory uses [11:2]
- mem_wdata  output  32  word to write
- mem_rdata  input  32  memory read data; synchronous read, valid the cycle after mem_addr is presented

Behaviour:
- Reset (reset=0, async):
  - state goes to IDLE.
  - req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal op/addr/data/word buffers cleared.
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE:
  - On accept, latch op, addr, wdata; mem_addr follows the latched addr from the next cycle.
  - Error check:
    - Halfword ops with addr[0]=1 are an error.
    - LW/SW with addr[1:0]!=0 are an error.
    - Any addr >= 4*2^MEM_WORDS_LOG2 is an error.
  - Error goes to RESP with err=1 and no memory access.
  - SW goes to WRITE with mem_wdata=wdata.
  - All other ops go to READ.
- READ: mem_we=0, mem_addr=latched addr; go to CAPTURE.
- CAPTURE: register mem_rdata into the word buffer.
  - For loads, extract and extend, then go to RESP.
  - For SB/SH, merge new bytes into the buffered word, then go to WRITE.
- WRITE: mem_we=1 for exactly this one cycle, mem_wdata=merged/store word; go to RESP.
- RESP: rsp_valid=1 for one cycle; go to IDLE.
- rsp_err and rsp_rdata are registered and hold until the next RESP.
- Byte order is little-endian:
  - byte k = word[8k+7:8k], k=addr[1:0].
  - halfword at addr[1]=0 is [15:0]; at addr[1]=1 it is [31:16].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unmodified.
- Merge: SB replaces only byte k; SH replaces only the addressed halfword; all other bits keep their read value.
- Latency from the accept edge to rsp_valid high:
  - misaligned or out-of-range: 1 cycle
  - SW: 2 cycles
  - loads: 3 cycles
  - SB/SH: 4 cycles
- req_ready is 0 outside IDLE. req_valid outside IDLE is ignored; there is no queuing and no implicit retry.
- Back-to-back: req_ready is high in the cycle after RESP, so a new request can be accepted on that edge.
- mem_we is decoded from the WRITE state only, never from inputs. An async reset therefore drops it immediately, and a write is never issued twice.
- Reset mid-operation aborts the request with no response. Memory is untouched unless the WRITE edge has already occurred. An RMW aborted before WRITE leaves memory unchanged.
- mem_rdata is ignored in every state except CAPTURE.

Test Plan:
- Memory word at byte address 0x10 preset to 0x8899AABB. LB 0x13 -> rsp_rdata=0xFFFFFF88, rsp_err=0, rsp_valid 3 cycles after accept, mem_we never high.
- LBU 0x11 -> 0x000000AA. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. LW 0x10 -> 0x8899AABB.
- SB 0x12, wdata 0x1234565C -> mem_we high for exactly 1 cycle with mem_wdata=0x885CAABB; rsp 4 cycles after accept, rsp_rdata=0; a following LW 0x10 returns 0x885CAABB.
- SH 0x13 and LW 0x16 -> rsp_err=1 after 1 cycle, no mem_we. Address 0x1000 with default param -> rsp_err=1.
- Reset asserted during CAPTURE of SB 0x10 -> outputs return to reset values immediately, word at 0x10 unchanged, req_ready=1 after release.
- Back-to-back SW 0x20=0xDEADBEEF then LW 0x20 with req_valid held high -> second accept on the cycle after the first rsp_valid, returns 0xDEADBEEF; req_valid pulses while busy produce no extra responses.
